// File: rtl/stopwatch_bcd_counter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// stopwatch_bcd_counter
//   Timekeeping core of the stopwatch. Divides the system clock down to a
//   TICK_HZ tick (one centisecond by default) and keeps elapsed time as six BCD
//   digits MM:SS.cc, wrapping 59:59.99 -> 00:00.00 while continuing to run.
//
//   Optional feature macro: STOPWATCH_LAP_HOLD_EN
//     When defined, i_Lap toggles a display hold in RUN. The displayed digits
//     freeze while the internal count keeps running. i_Lap in PAUSE releases
//     an active hold.
//
// Parameters
//   CLK_HZ   system clock frequency in Hz
//   TICK_HZ  count rate in Hz; CLK_HZ/TICK_HZ must be >= 2
//
// Ports
//   i_Clk         system clock, rising edge
//   i_Rst_n       asynchronous active-low reset
//   i_Start_Stop  1-cycle pulse: IDLE/PAUSE -> RUN, RUN -> PAUSE
//   i_Clear       1-cycle pulse: zero the time, go IDLE (highest priority)
//   i_Lap         1-cycle pulse: lap hold toggle (lap hold builds only)
//   o_Min10..o_Cs1  BCD digits MM:SS.cc, all registered
//   o_Running     1 while in RUN
//   o_Lap_Active  1 while the display is frozen by a lap hold
// -----------------------------------------------------------------------------
module stopwatch_bcd_counter #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Start_Stop,
  input  logic       i_Clear,
  input  logic       i_Lap,
  output logic [3:0] o_Min10,
  output logic [3:0] o_Min1,
  output logic [3:0] o_Sec10,
  output logic [3:0] o_Sec1,
  output logic [3:0] o_Cs10,
  output logic [3:0] o_Cs1,
  output logic       o_Running,
  output logic       o_Lap_Active
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic          running_q;

  logic [3:0] min10_q, min1_q, sec10_q, sec1_q, cs10_q, cs1_q;
  logic [3:0] min10_d, min1_d, sec10_d, sec1_d, cs10_d, cs1_d;
  logic       c_cs1, c_cs10, c_sec1, c_sec10, c_min1, unused_wrap;

  // Advance one BCD digit when en is set; returns {carry_out, next_digit}.
  // Using >= keeps the digit inside its range even from an unexpected value.
  function automatic logic [4:0] bcd_inc(input logic [3:0] d,
                                         input logic [3:0] max,
                                         input logic       en);
    if (!en)      return {1'b0, d};
    if (d >= max) return {1'b1, 4'd0};
    return {1'b0, d + 4'd1};
  endfunction

  // NOTE: each combinational block assigns a default to every output first,
  // so no branch can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (i_Clear) begin
      state_d = ST_IDLE;
    end else if (i_Start_Stop) begin
      unique case (state_q)
        ST_IDLE, ST_PAUSE: state_d = ST_RUN;
        ST_RUN:            state_d = ST_PAUSE;
        default:           state_d = ST_IDLE;
      endcase
    end
  end

  // The tick is judged on the current state, so a stop pulse on a tick edge
  // still lets that tick count before entering PAUSE.
  assign tick = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

  // Prescaler holds in PAUSE so a resumed run finishes the interrupted period.
  always_comb begin
    presc_d = presc_q;
    if (i_Clear || state_q == ST_IDLE) begin
      presc_d = '0;
    end else if (state_q == ST_RUN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  // Ripple carry through all six digits in a single edge.
  always_comb begin
    {c_cs1,       cs1_d}   = bcd_inc(cs1_q,   4'd9, tick);
    {c_cs10,      cs10_d}  = bcd_inc(cs10_q,  4'd9, c_cs1);
    {c_sec1,      sec1_d}  = bcd_inc(sec1_q,  4'd9, c_cs10);
    {c_sec10,     sec10_d} = bcd_inc(sec10_q, 4'd5, c_sec1);
    {c_min1,      min1_d}  = bcd_inc(min1_q,  4'd9, c_sec10);
    {unused_wrap, min10_d} = bcd_inc(min10_q, 4'd5, c_min1);
    if (i_Clear) begin
      cs1_d   = '0;
      cs10_d  = '0;
      sec1_d  = '0;
      sec10_d = '0;
      min1_d  = '0;
      min10_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      running_q <= 1'b0;
      min10_q   <= '0;
      min1_q    <= '0;
      sec10_q   <= '0;
      sec1_q    <= '0;
      cs10_q    <= '0;
      cs1_q     <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      running_q <= (state_d == ST_RUN);
      min10_q   <= min10_d;
      min1_q    <= min1_d;
      sec10_q   <= sec10_d;
      sec1_q    <= sec1_d;
      cs10_q    <= cs10_d;
      cs1_q     <= cs1_d;
    end
  end

  assign o_Running = running_q;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic       hold_q, hold_d;
  logic [3:0] disp_min10_q, disp_min1_q, disp_sec10_q, disp_sec1_q;
  logic [3:0] disp_cs10_q, disp_cs1_q;

  always_comb begin
    hold_d = hold_q;
    if (i_Clear) begin
      hold_d = 1'b0;
    end else if (i_Lap && state_q == ST_RUN) begin
      hold_d = !hold_q;
    end else if (i_Lap && state_q == ST_PAUSE) begin
      hold_d = 1'b0;
    end
  end

  // The display register follows the next count whenever the hold is off
  // after this edge; on the edge a hold starts it keeps what was shown.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hold_q       <= 1'b0;
      disp_min10_q <= '0;
      disp_min1_q  <= '0;
      disp_sec10_q <= '0;
      disp_sec1_q  <= '0;
      disp_cs10_q  <= '0;
      disp_cs1_q   <= '0;
    end else begin
      hold_q <= hold_d;
      if (!hold_d) begin
        disp_min10_q <= min10_d;
        disp_min1_q  <= min1_d;
        disp_sec10_q <= sec10_d;
        disp_sec1_q  <= sec1_d;
        disp_cs10_q  <= cs10_d;
        disp_cs1_q   <= cs1_d;
      end
    end
  end

  assign o_Min10      = disp_min10_q;
  assign o_Min1       = disp_min1_q;
  assign o_Sec10      = disp_sec10_q;
  assign o_Sec1       = disp_sec1_q;
  assign o_Cs10       = disp_cs10_q;
  assign o_Cs1        = disp_cs1_q;
  assign o_Lap_Active = hold_q;
`else
  logic unused_lap;
  assign unused_lap   = i_Lap;

  assign o_Min10      = min10_q;
  assign o_Min1       = min1_q;
  assign o_Sec10      = sec10_q;
  assign o_Sec1       = sec1_q;
  assign o_Cs10       = cs10_q;
  assign o_Cs1        = cs1_q;
  assign o_Lap_Active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
`timescale 1ns/1ps
// Testbench for stopwatch_bcd_counter (CLK_HZ=1000, TICK_HZ=100 -> DIV=10).
// A behavioural model keeps time as a plain centisecond count; each driven
// cycle can push the model's expected outputs onto a scoreboard queue that the
// scenario tasks pop and compare after the following rising edge.
module tb_stopwatch_bcd_counter;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int WRAP    = 360000;

`ifdef STOPWATCH_LAP_HOLD_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap_in = 1'b0;
  logic [3:0] min10, min1, sec10, sec1, cs10, cs1;
  logic       running, lap_active;

  always #5 clk = ~clk;

  stopwatch_bcd_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Start_Stop (start_stop),
    .i_Clear      (clear),
    .i_Lap        (lap_in),
    .o_Min10      (min10),
    .o_Min1       (min1),
    .o_Sec10      (sec10),
    .o_Sec1       (sec1),
    .o_Cs10       (cs10),
    .o_Cs1        (cs1),
    .o_Running    (running),
    .o_Lap_Active (lap_active)
  );

  typedef struct packed {
    logic [3:0] m10, m1, s10, s1, c10, c1;
    logic       run;
    logic       hold;
  } snap_t;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE} mstate_t;

  snap_t   sb[$];
  int      checks = 0;
  int      errors = 0;

  mstate_t m_state;
  int      m_pre, m_cs, m_disp;
  bit      m_hold;

  function automatic snap_t mk(input int cs_total, input bit run, input bit hold);
    snap_t s;
    int cc, ss, mm;
    cc = cs_total % 100;
    ss = (cs_total / 100) % 60;
    mm = cs_total / 6000;
    s.m10 = 4'(mm / 10); s.m1 = 4'(mm % 10);
    s.s10 = 4'(ss / 10); s.s1 = 4'(ss % 10);
    s.c10 = 4'(cc / 10); s.c1 = 4'(cc % 10);
    s.run = run;
    s.hold = hold;
    return s;
  endfunction

  function automatic snap_t model_snap();
    return mk(m_disp, m_state == M_RUN, m_hold);
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s = {min10, min1, sec10, sec1, cs10, cs1, running, lap_active};
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("%0d%0d:%0d%0d.%0d%0d run=%0b lap=%0b",
                     s.m10, s.m1, s.s10, s.s1, s.c10, s.c1, s.run, s.hold);
  endfunction

  function automatic void model_reset();
    m_state = M_IDLE;
    m_pre = 0;
    m_cs = 0;
    m_disp = 0;
    m_hold = 1'b0;
  endfunction

  function automatic void model_step(input bit ss, input bit clr, input bit lp);
    bit tick;
    if (clr) begin
      model_reset();
      return;
    end
    tick = (m_state == M_RUN) && (m_pre == DIV - 1);
    if (LAP_EN && lp) begin
      if (m_state == M_RUN)        m_hold = !m_hold;
      else if (m_state == M_PAUSE) m_hold = 1'b0;
    end
    if (m_state == M_RUN)       m_pre = tick ? 0 : m_pre + 1;
    else if (m_state == M_IDLE) m_pre = 0;
    if (tick) m_cs = (m_cs + 1) % WRAP;
    if (ss) m_state = (m_state == M_RUN) ? M_PAUSE : M_RUN;
    if (!m_hold) m_disp = m_cs;
  endfunction

  // Drive one cycle of pulses at the falling edge, step the model, optionally
  // queue the expected post-edge outputs, then land 1 ns after the rising edge.
  task automatic cycle(input bit ss, input bit clr, input bit lp, input bit push);
    @(negedge clk);
    start_stop = ss;
    clear      = clr;
    lap_in     = lp;
    model_step(ss, clr, lp);
    if (push) sb.push_back(model_snap());
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap_in     = 1'b0;
  endtask

  task automatic test_reset();
    snap_t exp, obs;
    rst_n = 1'b0;
    model_reset();
    sb.push_back(model_snap());
    repeat (2) @(posedge clk);
    #1;
    exp = sb.pop_front(); obs = dut_snap(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset got %s want %s", fmt(obs), fmt(exp)); end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 0, 1);
    exp = sb.pop_front(); obs = dut_snap(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL idle_hold got %s want %s", fmt(obs), fmt(exp)); end
    cycle(0, 0, 1, 1);
    exp = sb.pop_front(); obs = dut_snap(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL lap_in_idle got %s want %s", fmt(obs), fmt(exp)); end
  endtask

  task automatic test_first_tick();
    snap_t exp, obs;
    cycle(1, 0, 0, 0);
    for (int i = 1; i <= DIV; i++) begin
      cycle(0, 0, 0, 1);
      exp = sb.pop_front(); obs = dut_snap(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL first_tick_c%0d got %s want %s", i, fmt(obs), fmt(exp)); end
    end
    exp = mk(1, 1'b1, 1'b0); checks++;
    if (obs !== exp) begin errors++; $display("FAIL first_tick_exact got %s want %s", fmt(obs), fmt(exp)); end
  endtask

  task automatic test_run_1000();
    snap_t exp, obs;
    int bad;
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 1000 * DIV; i++) begin
      cycle(0, 0, 0, 1);
      exp = sb.pop_front(); obs = dut_snap(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL run_seq_c%0d got %s want %s", i, fmt(obs), fmt(exp)); end
      bad = (obs.c1 > 9 || obs.c10 > 9 || obs.s1 > 9 || obs.s10 > 5 || obs.m1 > 9 || obs.m10 > 5) ? 1 : 0;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL bcd_range_c%0d got %s want all digits in range", i, fmt(obs)); end
    end
    exp = mk(1000, 1'b1, 1'b0); checks++;
    if (obs !== exp) begin errors++; $display("FAIL run_1000 got %s want %s", fmt(obs), fmt(exp)); end
  endtask

  // Preload 59:59.99 while running, just after a tick edge (prescaler 0).
  task automatic test_wrap();
    snap_t exp, obs;
    #1;
    force dut.min10_q = 4'd5;
    force dut.min1_q  = 4'd9;
    force dut.sec10_q = 4'd5;
    force dut.sec1_q  = 4'd9;
    force dut.cs10_q  = 4'd9;
    force dut.cs1_q   = 4'd9;
    #1;
    release dut.min10_q;
    release dut.min1_q;
    release dut.sec10_q;
    release dut.sec1_q;
    release dut.cs10_q;
    release dut.cs1_q;
    m_cs = WRAP - 1;
    m_disp = m_cs;
    for (int i = 1; i <= DIV; i++) begin
      cycle(0, 0, 0, 1);
      exp = sb.pop_front(); obs = dut_snap(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL wrap_c%0d got %s want %s", i, fmt(obs), fmt(exp)); end
    end
    exp = mk(0, 1'b1, 1'b0); checks++;
    if (obs !== exp) begin errors++; $display("FAIL wrap_zero got %s want %s", fmt(obs), fmt(exp)); end
  endtask

  task automatic test_pause_resume();
    snap_t exp, obs;
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 1);
    exp = sb.pop_front(); obs = dut_snap(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL pause_enter got %s want %s", fmt(obs), fmt(exp)); end
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, (i == 19));
    exp = sb.pop_front(); obs = dut_snap(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL pause_hold got %s want %s", fmt(obs), fmt(exp)); end
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, (i == 5));
    exp = sb.pop_front(); obs = dut_snap(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL resume_model got %s want %s", fmt(obs), fmt(exp)); end
    exp = mk(1, 1'b1, 1'b0); checks++;
    if (obs !== exp) begin errors++; $display("FAIL resume_exact got %s want %s", fmt(obs), fmt(exp)); end
  endtask

  task automatic test_stop_on_tick();
    snap_t exp, obs;
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (DIV - 1) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 1);
    exp = sb.pop_front(); obs = dut_snap(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL stop_on_tick got %s want %s", fmt(obs), fmt(exp)); end
    exp = mk(1, 1'b0, 1'b0); checks++;
    if (obs !== exp) begin errors++; $display("FAIL stop_on_tick_exact got %s want %s", fmt(obs), fmt(exp)); end
    for (int i = 0; i < 15; i++) cycle(0, 0, 0, (i == 14));
    exp = sb.pop_front(); obs = dut_snap(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL stop_stays got %s want %s", fmt(obs), fmt(exp)); end
  endtask

  task automatic test_clear_priority();
    snap_t exp, obs;
    cycle(1, 0, 0, 0);
    repeat (37) cycle(0, 0, 0, 0);
    cycle(1, 1, 1, 1);
    exp = sb.pop_front(); obs = dut_snap(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL clear_prio got %s want %s", fmt(obs), fmt(exp)); end
    exp = mk(0, 1'b0, 1'b0); checks++;
    if (obs !== exp) begin errors++; $display("FAIL clear_prio_exact got %s want %s", fmt(obs), fmt(exp)); end
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, (i == 11));
    exp = sb.pop_front(); obs = dut_snap(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL clear_idle got %s want %s", fmt(obs), fmt(exp)); end
  endtask

  task automatic test_lap();
    snap_t exp, obs;
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (5 * DIV) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 1);
    exp = sb.pop_front(); obs = dut_snap(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL lap_on got %s want %s", fmt(obs), fmt(exp)); end
    for (int i = 0; i < 5 * DIV - 1; i++) cycle(0, 0, 0, (i == 5 * DIV - 2));
    exp = sb.pop_front(); obs = dut_snap(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL lap_frozen got %s want %s", fmt(obs), fmt(exp)); end
    exp = mk(LAP_EN ? 5 : 10, 1'b1, LAP_EN); checks++;
    if (obs !== exp) begin errors++; $display("FAIL lap_frozen_exact got %s want %s", fmt(obs), fmt(exp)); end
    cycle(0, 0, 1, 1);
    exp = sb.pop_front(); obs = dut_snap(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL lap_off got %s want %s", fmt(obs), fmt(exp)); end
    exp = mk(10, 1'b1, 1'b0); checks++;
    if (obs !== exp) begin errors++; $display("FAIL lap_off_exact got %s want %s", fmt(obs), fmt(exp)); end
    // Hold again, pause, then a lap pulse in PAUSE releases the hold.
    cycle(0, 0, 1, 0);
    repeat (13) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 1);
    exp = sb.pop_front(); obs = dut_snap(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL lap_paused got %s want %s", fmt(obs), fmt(exp)); end
    cycle(0, 0, 1, 1);
    exp = sb.pop_front(); obs = dut_snap(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL lap_release_pause got %s want %s", fmt(obs), fmt(exp)); end
  endtask

  task automatic test_reset_mid();
    snap_t exp, obs;
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (37) cycle(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    exp = mk(0, 1'b0, 1'b0); obs = dut_snap(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_async got %s want %s", fmt(obs), fmt(exp)); end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 0, 0);
    for (int i = 1; i <= DIV; i++) begin
      cycle(0, 0, 0, 1);
      exp = sb.pop_front(); obs = dut_snap(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_restart_c%0d got %s want %s", i, fmt(obs), fmt(exp)); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_tick();
    test_run_1000();
    test_wrap();
    test_pause_resume();
    test_stop_on_tick();
    test_clear_priority();
    test_lap();
    test_reset_mid();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
